// File: rtl/game_dumper.sv
// ---------------------------------------------------------------------------
// game_dumper
//
// Rebuilds an iNES image from a game already loaded into SDRAM and streams it
// out one byte at a time, for the IO-controller upload (save/dump ROM) path.
// A 16-byte iNES header is generated from the mapper flags latched at start.
// PRG bytes are then read from PRG_BASE, followed by CHR bytes from CHR_BASE.
// The CHR section is skipped when the cart uses CHR RAM. The address map is
// the same as the loader's SDRAM write side.
//
// Only one SDRAM read is outstanding at a time. A new read is never issued
// while a stream byte is still waiting to be accepted.
//
// Optional build macro:
//   GAME_DUMPER_CHECKSUM_EN - appends two trailer bytes, low byte first. They
//                             hold the 16-bit sum of all PRG+CHR bytes.
//
// Ports:
//   clk           system clock
//   reset         asynchronous, active-high reset
//   start         one-cycle pulse that begins a dump (ignored while busy)
//   mapper_flags  [7:0] mapper, [10:8] prg_size, [13:11] chr_size,
//                 [14] mirroring, [15] has_chr_ram, [16] four_screen
//   mem_addr      SDRAM byte address of the current read
//   mem_rd        read request, held until mem_ack
//   mem_ack       read complete, mem_data valid this cycle
//   mem_data      SDRAM read data
//   out_data      stream byte
//   out_valid     stream byte available
//   out_ready     sink accepts the byte (transfer = out_valid && out_ready)
//   busy          dump in progress
//   done          sticky; set on the last transfer, cleared by start
// ---------------------------------------------------------------------------
module game_dumper #(
  parameter logic [21:0] PRG_BASE = 22'h000000,
  parameter logic [21:0] CHR_BASE = 22'h200000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] mapper_flags,
  output logic [21:0] mem_addr,
  output logic        mem_rd,
  input  logic        mem_ack,
  input  logic [7:0]  mem_data,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_FETCH,
    S_WAIT,
`ifdef GAME_DUMPER_CHECKSUM_EN
    S_EMIT,
    S_CSUM
`else
    S_EMIT
`endif
  } state_t;

  state_t      state;
  logic [16:0] flags;      // only the defined flag bits are kept
  logic [3:0]  hdr_idx;
  logic        phase_chr;
  logic [21:0] addr;
  logic [21:0] count;      // bytes left in the current phase
`ifdef GAME_DUMPER_CHECKSUM_EN
  logic [15:0] csum;
  logic        csum_idx;
`endif

  // Bits [31:17] carry no meaning for the dump.
  logic unused_flags;
  assign unused_flags = ^mapper_flags[31:17];

  function automatic logic [7:0] hdr_byte(input logic [3:0] idx, input logic [16:0] f);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      4'd0:    b = 8'h4E;
      4'd1:    b = 8'h45;
      4'd2:    b = 8'h53;
      4'd3:    b = 8'h1A;
      4'd4:    b = 8'd1 << f[10:8];
      4'd5:    b = f[15] ? 8'h00 : (8'd1 << f[13:11]);
      4'd6:    b = {f[3:0], f[16], 2'b00, f[14]};
      4'd7:    b = {f[7:4], 4'h0};
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // 16 KiB PRG pages: prg_size 7 gives 2^21, which still fits in 22 bits.
  function automatic logic [21:0] prg_bytes(input logic [16:0] f);
    logic [4:0] sh;
    sh = {2'b00, f[10:8]} + 5'd14;
    return 22'd1 << sh;
  endfunction

  // 8 KiB CHR pages.
  function automatic logic [21:0] chr_bytes(input logic [16:0] f);
    logic [4:0] sh;
    sh = {2'b00, f[13:11]} + 5'd13;
    return 22'd1 << sh;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      flags     <= '0;
      hdr_idx   <= '0;
      phase_chr <= 1'b0;
      addr      <= '0;
      count     <= '0;
      mem_addr  <= '0;
      mem_rd    <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef GAME_DUMPER_CHECKSUM_EN
      csum      <= '0;
      csum_idx  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            flags     <= mapper_flags[16:0];
            busy      <= 1'b1;
            done      <= 1'b0;
            hdr_idx   <= 4'd0;
            out_data  <= hdr_byte(4'd0, mapper_flags[16:0]);
            out_valid <= 1'b1;
            state     <= S_HDR;
`ifdef GAME_DUMPER_CHECKSUM_EN
            csum      <= '0;
`endif
          end
        end

        S_HDR: begin
          if (out_valid && out_ready) begin
            if (hdr_idx == 4'd15) begin
              out_valid <= 1'b0;
              phase_chr <= 1'b0;
              addr      <= PRG_BASE;
              count     <= prg_bytes(flags);
              state     <= S_FETCH;
            end else begin
              hdr_idx  <= hdr_idx + 4'd1;
              out_data <= hdr_byte(hdr_idx + 4'd1, flags);
            end
          end
        end

        S_FETCH: begin
          mem_rd   <= 1'b1;
          mem_addr <= addr;
          state    <= S_WAIT;
        end

        S_WAIT: begin
          if (mem_ack) begin
            out_data  <= mem_data;
            out_valid <= 1'b1;
            mem_rd    <= 1'b0;
            state     <= S_EMIT;
`ifdef GAME_DUMPER_CHECKSUM_EN
            csum      <= csum + {8'h00, mem_data};
`endif
          end
        end

        S_EMIT: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            addr      <= addr + 22'd1;
            count     <= count - 22'd1;
            if (count == 22'd1) begin
              // 1 << chr_size is never zero, so CHR is present unless CHR RAM.
              if (!phase_chr && !flags[15]) begin
                phase_chr <= 1'b1;
                addr      <= CHR_BASE;
                count     <= chr_bytes(flags);
                state     <= S_FETCH;
              end else begin
`ifdef GAME_DUMPER_CHECKSUM_EN
                // The sum already includes this last byte: it is added on ack.
                out_data  <= csum[7:0];
                out_valid <= 1'b1;
                csum_idx  <= 1'b0;
                state     <= S_CSUM;
`else
                busy      <= 1'b0;
                done      <= 1'b1;
                state     <= S_IDLE;
`endif
              end
            end else begin
              state <= S_FETCH;
            end
          end
        end

`ifdef GAME_DUMPER_CHECKSUM_EN
        S_CSUM: begin
          if (out_valid && out_ready) begin
            if (!csum_idx) begin
              out_data <= csum[15:8];
              csum_idx <= 1'b1;
            end else begin
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= S_IDLE;
            end
          end
        end
`endif

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_dumper.sv
// ---------------------------------------------------------------------------
// tb_game_dumper
//
// Directed testbench for game_dumper. An SDRAM model answers reads with a
// byte derived from the address. The ack delay is programmable. The model can
// also raise stray acks while no read is pending. Each scenario task drives
// the stimulus and checks the results inline. Expected headers are
// hand-computed from the flag words used.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_game_dumper;

  localparam int PRG0 = 16384;   // prg_size 0
  localparam int CHR0 = 8192;    // chr_size 0

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] mapper_flags;
  logic [21:0] mem_addr;
  logic        mem_rd;
  logic        mem_ack;
  logic [7:0]  mem_data;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  int ack_delay = 0;
  bit spurious  = 1'b0;
  int ack_cnt   = 0;

  always #5 clk = ~clk;

  game_dumper dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .mapper_flags (mapper_flags),
    .mem_addr     (mem_addr),
    .mem_rd       (mem_rd),
    .mem_ack      (mem_ack),
    .mem_data     (mem_data),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .busy         (busy),
    .done         (done)
  );

  function automatic logic [7:0] rom_val(input logic [21:0] a);
    return a[7:0] ^ a[15:8] ^ {2'b00, a[21:16]};
  endfunction

  // SDRAM model: updates on the falling edge, so the DUT samples stable values.
  initial begin
    int wcnt;
    wcnt     = 0;
    mem_ack  = 1'b0;
    mem_data = 8'h00;
    forever begin
      @(negedge clk);
      if (mem_rd) begin
        if (wcnt >= ack_delay) begin
          mem_ack  = 1'b1;
          mem_data = rom_val(mem_addr);
          wcnt     = 0;
          ack_cnt++;
        end else begin
          mem_ack = 1'b0;
          wcnt++;
        end
      end else if (spurious) begin
        mem_ack  = 1'b1;
        mem_data = 8'hEE;
        wcnt     = 0;
      end else begin
        mem_ack = 1'b0;
        wcnt    = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; out_ready = 1'b0; mapper_flags = 32'h0;
    repeat (3) tick();
    checks++; if (mem_addr !== 22'h0) begin failures++; $display("FAIL reset_mem_addr got=%h exp=000000", mem_addr); end
    checks++; if (mem_rd !== 1'b0) begin failures++; $display("FAIL reset_mem_rd got=%b exp=0", mem_rd); end
    checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    reset = 1'b0;
    repeat (2) tick();
  endtask

  // Full dump with 16 KiB PRG and 8 KiB CHR. It includes a start pulse while
  // busy, a flag change after start, and a start coinciding with the last
  // transfer.
  task automatic test_full_dump();
    logic [7:0]  hdr [16];
    logic [7:0]  exp_b, fb_got, fb_exp;
    logic [21:0] exp_a, fa_got, fa_exp;
    logic [15:0] sum;
    logic        last_rd;
    bit          busy_start_done;
    int          total, n, cyc, rd_idx, bad_d, bad_a, fb_n;
    // flags 0x4013: mapper 0x13, prg 0, chr 0, mirroring 1
    hdr = '{8'h4E, 8'h45, 8'h53, 8'h1A, 8'h01, 8'h01, 8'h31, 8'h10,
            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    sum = 16'h0;
    for (int i = 0; i < PRG0; i++) sum = sum + {8'h00, rom_val(22'(i))};
    for (int i = 0; i < CHR0; i++) sum = sum + {8'h00, rom_val(22'h200000 + 22'(i))};
    total = 16 + PRG0 + CHR0;
`ifdef GAME_DUMPER_CHECKSUM_EN
    total = total + 2;
`endif
    mapper_flags = 32'h0000_4013; out_ready = 1'b1; ack_delay = 0;
    start = 1'b1; tick(); start = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL full_busy_after_start got=%b exp=1", busy); end

    n = 0; cyc = 0; rd_idx = 0; bad_d = 0; bad_a = 0; fb_n = -1; last_rd = 1'b0;
    busy_start_done = 1'b0; fb_got = 0; fb_exp = 0; fa_got = 0; fa_exp = 0;
    while (n < total && cyc < 80000) begin
      start = 1'b0;
      if (mem_rd && !last_rd) begin
        exp_a = (rd_idx < PRG0) ? 22'(rd_idx) : 22'h200000 + 22'(rd_idx - PRG0);
        if (mem_addr !== exp_a) begin
          if (bad_a == 0) begin fa_got = mem_addr; fa_exp = exp_a; end
          bad_a++;
        end
        rd_idx++;
      end
      last_rd = mem_rd;
      if (out_valid) begin
        if (n < 16) exp_b = hdr[n];
        else if (n < 16 + PRG0) exp_b = rom_val(22'(n - 16));
        else if (n < 16 + PRG0 + CHR0) exp_b = rom_val(22'h200000 + 22'(n - 16 - PRG0));
        else if (n == 16 + PRG0 + CHR0) exp_b = sum[7:0];
        else exp_b = sum[15:8];
        if (out_data !== exp_b) begin
          if (bad_d == 0) begin fb_n = n; fb_got = out_data; fb_exp = exp_b; end
          bad_d++;
        end
        if (n == total - 1) start = 1'b1;   // start lands with the final transfer
        n++;
        if (n == 20 && !busy_start_done) begin
          busy_start_done = 1'b1;
          start = 1'b1;
          mapper_flags = 32'hFFFF_FFFF;
        end
      end
      tick(); cyc++;
    end
    start = 1'b0;
    checks++; if (n !== total) begin failures++; $display("FAIL full_transfers got=%0d exp=%0d", n, total); end
    checks++; if (bad_d !== 0) begin failures++; $display("FAIL full_stream_bytes bad=%0d first_idx=%0d got=%h exp=%h", bad_d, fb_n, fb_got, fb_exp); end
    checks++; if (bad_a !== 0) begin failures++; $display("FAIL full_read_addr bad=%0d got=%h exp=%h", bad_a, fa_got, fa_exp); end
    checks++; if (rd_idx !== PRG0 + CHR0) begin failures++; $display("FAIL full_read_count got=%0d exp=%0d", rd_idx, PRG0 + CHR0); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL full_valid_after_last got=%b exp=0", out_valid); end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL full_done got=%b exp=1", done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL full_busy_end got=%b exp=0", busy); end
    repeat (3) tick();
    checks++; if (busy !== 1'b0 || mem_rd !== 1'b0) begin failures++; $display("FAIL full_start_at_done_ignored busy=%b mem_rd=%b exp=0/0", busy, mem_rd); end
  endtask

  // CHR-RAM cart header; PRG reads begin at PRG_BASE. Also checks done clears on start.
  task automatic test_chr_ram_header();
    logic [7:0] hdr [16];
    logic [7:0] got [16];
    logic [7:0] exp_b;
    logic       last_rd;
    int         n, cyc, rd_idx, bad, bad_a;
    // flags 0x8302: mapper 2, prg_size 3, has_chr_ram
    hdr = '{8'h4E, 8'h45, 8'h53, 8'h1A, 8'h08, 8'h00, 8'h20, 8'h00,
            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 16; i++) got[i] = 8'hXX;
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL done_sticky got=%b exp=1", done); end
    mapper_flags = 32'h0000_8302; out_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL done_cleared_by_start got=%b exp=0", done); end
    n = 0; cyc = 0; rd_idx = 0; bad = 0; bad_a = 0; last_rd = 1'b0;
    while ((n < 20 || rd_idx < 4) && cyc < 200) begin
      if (mem_rd && !last_rd) begin
        if (mem_addr !== 22'(rd_idx)) bad_a++;
        rd_idx++;
      end
      last_rd = mem_rd;
      if (out_valid) begin
        if (n < 16) got[n] = out_data;
        exp_b = (n < 16) ? hdr[n] : rom_val(22'(n - 16));
        if (out_data !== exp_b) bad++;
        n++;
      end
      tick(); cyc++;
    end
    checks++; if (got[4] !== 8'h08) begin failures++; $display("FAIL chrram_hdr4 got=%h exp=08", got[4]); end
    checks++; if (got[5] !== 8'h00) begin failures++; $display("FAIL chrram_hdr5 got=%h exp=00", got[5]); end
    checks++; if (got[6] !== 8'h20) begin failures++; $display("FAIL chrram_hdr6 got=%h exp=20", got[6]); end
    checks++; if (bad !== 0 || n < 20) begin failures++; $display("FAIL chrram_stream bad=%0d bytes=%0d exp_bytes=20", bad, n); end
    checks++; if (bad_a !== 0 || rd_idx < 4) begin failures++; $display("FAIL chrram_read_addr bad=%0d reads=%0d exp_reads=4", bad_a, rd_idx); end
    reset = 1'b1; tick(); reset = 1'b0; tick();
  endtask

  // Ready toggling during the header, then a 5-cycle stall on a ROM byte.
  task automatic test_backpressure();
    logic [7:0] hdr [16];
    logic [7:0] exp_b, held;
    int         n, cyc, bad, bad_stall, stall_left, stalls_seen;
    bit         stalled;
    // flags 0x13A45: mapper 0x45, prg_size 2, chr_size 7, four_screen
    hdr = '{8'h4E, 8'h45, 8'h53, 8'h1A, 8'h04, 8'h80, 8'h58, 8'h40,
            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    mapper_flags = 32'h0001_3A45; out_ready = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    n = 0; cyc = 0; bad = 0; bad_stall = 0; stall_left = 0; stalls_seen = 0;
    stalled = 1'b0; held = 8'h00;
    while (n < 46 && cyc < 2000) begin
      out_ready = (n < 16) ? ((cyc % 2) == 0) : 1'b1;
      if (n == 26 && out_valid && !stalled) begin
        stalled = 1'b1; stall_left = 5; held = out_data;
      end
      if (stall_left > 0) begin
        out_ready = 1'b0;
        if (out_valid !== 1'b1 || out_data !== held || mem_rd !== 1'b0) bad_stall++;
        stall_left--; stalls_seen++;
      end
      if (out_valid && out_ready) begin
        exp_b = (n < 16) ? hdr[n] : rom_val(22'(n - 16));
        if (out_data !== exp_b) bad++;
        n++;
      end
      tick(); cyc++;
    end
    checks++; if (bad !== 0 || n !== 46) begin failures++; $display("FAIL bp_stream bad=%0d bytes=%0d exp_bytes=46", bad, n); end
    checks++; if (bad_stall !== 0 || stalls_seen !== 5) begin failures++; $display("FAIL bp_stall_hold bad=%0d stall_cycles=%0d exp=0/5", bad_stall, stalls_seen); end
    out_ready = 1'b1;
    reset = 1'b1; tick(); reset = 1'b0; tick();
  endtask

  // Slow SDRAM with stray acks outside the wait state.
  task automatic test_ack_delay();
    logic [7:0]  hdr [16];
    logic [7:0]  exp_b;
    logic [21:0] held_a;
    logic        last_rd;
    bit          exp_vnext;
    int          n, cyc, bad, bad_hold, bad_wait, bad_lat, wait_len, a0, hdr4;
    // flags 0x0700: mapper 0, prg_size 7, chr_size 0
    hdr = '{8'h4E, 8'h45, 8'h53, 8'h1A, 8'h80, 8'h01, 8'h00, 8'h00,
            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    mapper_flags = 32'h0000_0700; out_ready = 1'b1; ack_delay = 7; spurious = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    a0 = ack_cnt;
    n = 0; cyc = 0; bad = 0; bad_hold = 0; bad_wait = 0; bad_lat = 0; wait_len = 0;
    exp_vnext = 1'b0; last_rd = 1'b0; held_a = '0; hdr4 = -1;
    while (n < 24 && cyc < 500) begin
      if (exp_vnext) begin
        if (out_valid !== 1'b1 || out_data !== rom_val(22'(n - 16))) bad_lat++;
        exp_vnext = 1'b0;
      end
      if (mem_rd) begin
        if (!last_rd) begin held_a = mem_addr; wait_len = 0; end
        else if (mem_addr !== held_a) bad_hold++;
        wait_len++;
        if (mem_ack && last_rd) exp_vnext = 1'b1;
      end else if (last_rd) begin
        if (wait_len != 8) bad_wait++;
      end
      last_rd = mem_rd;
      if (out_valid) begin
        exp_b = (n < 16) ? hdr[n] : rom_val(22'(n - 16));
        if (n == 4) hdr4 = int'(out_data);
        if (out_data !== exp_b) bad++;
        n++;
      end
      tick(); cyc++;
    end
    checks++; if (hdr4 !== 32'h80) begin failures++; $display("FAIL ack_hdr4_prg7 got=%h exp=80", hdr4); end
    checks++; if (bad !== 0 || n !== 24) begin failures++; $display("FAIL ack_stream bad=%0d bytes=%0d exp_bytes=24", bad, n); end
    checks++; if (bad_hold !== 0) begin failures++; $display("FAIL ack_addr_hold changes=%0d exp=0", bad_hold); end
    checks++; if (bad_wait !== 0) begin failures++; $display("FAIL ack_rd_hold bad_waits=%0d exp=0", bad_wait); end
    checks++; if (bad_lat !== 0) begin failures++; $display("FAIL ack_to_valid_latency bad=%0d exp=0", bad_lat); end
    checks++; if (ack_cnt - a0 !== 8) begin failures++; $display("FAIL ack_one_byte_per_ack acks=%0d exp=8", ack_cnt - a0); end
    spurious = 1'b0; ack_delay = 0;
    reset = 1'b1; tick(); reset = 1'b0; tick();
  endtask

  // Asynchronous reset with a read in flight, then a fresh dump.
  task automatic test_reset_mid();
    logic [7:0] hdr [16];
    int         n, cyc, bad;
    bit         found;
    hdr = '{8'h4E, 8'h45, 8'h53, 8'h1A, 8'h01, 8'h01, 8'h31, 8'h10,
            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    mapper_flags = 32'h0000_4013; out_ready = 1'b1; ack_delay = 2;
    start = 1'b1; tick(); start = 1'b0;
    n = 0; cyc = 0;
    while (n < 116 && cyc < 2000) begin
      if (out_valid) n++;
      tick(); cyc++;
    end
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (mem_rd) found = 1'b1;
      else tick();
    end
    checks++; if (!found || n !== 116) begin failures++; $display("FAIL rst_mid_reach_read found=%b bytes=%0d exp=1/116", found, n); end
    #2 reset = 1'b1;
    #1;
    checks++; if (mem_rd !== 1'b0) begin failures++; $display("FAIL rst_mid_mem_rd got=%b exp=0", mem_rd); end
    checks++; if (mem_addr !== 22'h0) begin failures++; $display("FAIL rst_mid_mem_addr got=%h exp=000000", mem_addr); end
    checks++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin failures++; $display("FAIL rst_mid_out got=%b/%h exp=0/00", out_valid, out_data); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rst_mid_status got=%b/%b exp=0/0", busy, done); end
    repeat (2) tick();
    reset = 1'b0; ack_delay = 0;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h4E) begin failures++; $display("FAIL rst_mid_restart got=%b/%h exp=1/4e", out_valid, out_data); end
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (out_valid !== 1'b1 || out_data !== hdr[i]) bad++;
      tick();
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL rst_mid_hdr_back_to_back bad=%0d exp=0", bad); end
    reset = 1'b1; tick(); reset = 1'b0; tick();
  endtask

  initial begin
    test_reset();
    test_full_dump();
    test_chr_ram_header();
    test_backpressure();
    test_ack_delay();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/game_dumper.md
Name: game_dumper

Overview:
- Inverse of the iNES game loader: rebuilds an iNES image from the loaded game in SDRAM and streams it out byte by byte.
- The stream feeds the IO-controller upload path (save/dump ROM).
- Generates a 16-byte iNES header from mapper_flags, then reads PRG from PRG_BASE and CHR from CHR_BASE.
- Sits beside the loader in the top level and shares the loader's SDRAM write-side addressing map.

Parameters:
- PRG_BASE, 22'h000000, SDRAM byte address of the first PRG byte.
- CHR_BASE, 22'h200000, SDRAM byte address of the first CHR byte.

Ports:
- clk  in  1  system clock; the block has one clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a dump; ignored while busy.
- mapper_flags  in  32  bits [7:0] mapper, [10:8] prg_size, [13:11] chr_size, [14] mirroring, [15] has_chr_ram, [16] four_screen.
- mem_addr  out  22  SDRAM byte address.
- mem_rd  out  1  read request; held until mem_ack.
- mem_ack  in  1  read complete; mem_data is valid in this cycle.
- mem_data  in  8  read data.
- out_data  out  8  stream byte.
- out_valid  out  1  stream byte available.
- out_ready  in  1  sink accepts the byte; transfer happens when out_valid && out_ready.
- busy  out  1  dump in progress.
- done  out  1  sticky; set when the last byte transfers, cleared by start.

Behaviour:
- Reset (async): state IDLE. mem_addr=0, mem_rd=0, out_data=0, out_valid=0, busy=0, done=0.
- On start in IDLE: latch mapper_flags, set busy=1, clear done, go to HDR with index 0.
- Header bytes:
  - 0..3 = 4E 45 53 1A.
  - 4 = prg_pages = 1<<prg_size (prg_size 7 gives 8'h80).
  - 5 = has_chr_ram ? 0 : 1<<chr_size.
  - 6 = {mapper[3:0], four_screen, 1'b0, 1'b0, mirroring}.
  - 7 = {mapper[7:4], 4'b0}.
  - 8..15 = 00.
- HDR: out_valid=1 with the header byte. The index advances on transfer. After byte 15 transfers, go to FETCH with phase=PRG, addr=PRG_BASE, count=prg_pages*16384 (22-bit, max 2^21).
- FETCH: assert mem_rd with mem_addr=addr, go to WAIT.
- WAIT: mem_rd and mem_addr held stable until mem_ack. On mem_ack, register mem_data into out_data, set out_valid=1, drop mem_rd, go to EMIT.
- EMIT: hold out_data and out_valid until transfer. On transfer: addr+1, count-1.
  - If count becomes 0 and phase=PRG: go to CHR if chr bytes are nonzero, else END.
  - Otherwise go back to FETCH.
- Only one read is outstanding at a time. No mem_rd is issued while a byte is pending on the stream.
- CHR phase: addr=CHR_BASE, count=(1<<chr_size)*8192. Skipped entirely when has_chr_ram=1, so no read reaches CHR_BASE.
- END: busy=0, done=1, state IDLE. out_valid falls in the cycle after the last transfer.
- Latency: header byte n+1 is valid in the cycle after byte n transfers. A ROM byte is valid in the cycle after mem_ack.
- Simultaneous events:
  - start while busy: ignored.
  - start in the same cycle done would set: the block finishes first and the start is ignored.
  - mem_ack outside WAIT: ignored.
- mapper_flags changes after start have no effect until the next start.
- Reset mid-dump: immediate return to IDLE with all outputs at reset values. The in-flight SDRAM read is abandoned.

Optional Feature:
- Macro: GAME_DUMPER_CHECKSUM_EN.
- With the macro:
  - A 16-bit sum of all PRG+CHR bytes (header excluded), mod 65536, is kept.
  - After the last ROM byte, state CSUM emits two trailer bytes, low byte first, with the same valid/ready rules; then END.
  - The sum clears on start.
- Without the macro: no accumulator, no CSUM state, and the stream ends at the last ROM byte.

Test Plan:
1. mapper_flags=32'h0000_4100 (mapper 0, prg_size 1, chr_size 0, mirroring 1), start, out_ready=1, memory returns addr[7:0] with 2-cycle ack:
   - Header is 4E 45 53 1A 02 01 01 00 then 8x00.
   - Then 32768 bytes from 0x000000..0x007FFF, then 8192 from 0x200000..0x201FFF.
   - 40976 transfers total, then done=1 and busy=0.
2. has_chr_ram=1, mapper=2, prg_size=3:
   - Byte 4 = 08, byte 5 = 00, byte 6 = 20.
   - 131072 PRG bytes, and mem_addr never reaches ≥0x200000.
3. out_ready held low for 5 cycles mid-PRG: out_data and out_valid stay stable, mem_rd stays 0, and there is no dropped or duplicated byte versus the address sequence.
4. mem_ack delayed 7 cycles: mem_rd and mem_addr stay constant through the wait, and exactly one byte is emitted per ack.
5. reset asserted after 100 PRG bytes, then start again: outputs are zero during reset, and the stream restarts from header byte 4E.
6. GAME_DUMPER_CHECKSUM_EN with test 1 data: two trailer bytes equal to the sum of all ROM bytes mod 65536, low byte first; 40978 transfers total.
